// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory req/ack port bundle
//
// Purpose: groups the req/ack data-memory port driven by mem_access.
// Signals:
//   dm_req   request, held until dm_ack or timeout
//   dm_we    1 = store, 0 = load
//   dm_addr  word-aligned address
//   dm_wdata lane-replicated store data
//   dm_be    byte enables
//   dm_ack   completion from memory; dm_rdata valid with it
//   dm_rdata read word
// Modports: master (the access stage), slave (the memory).
interface mem_access_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage with req/ack data port
//
// Purpose: turns the EX result into a single data-memory transfer, stalls
// the pipeline while it is outstanding, formats load data and flags
// misaligned accesses and bus timeouts.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_valid_in, i_flush instruction valid / kill from EX
//   i_mem_rd, i_mem_wr  load / store
//   i_mem_size          00 byte, 01 half, 10 word, 11 reserved
//   i_mem_unsigned      zero-extend loads
//   i_c, i_rf_rd2       effective address, store data
//   dm                  data-memory port (mem_access_if.master)
//   o_stall, o_done     hold upstream / one-cycle completion pulse
//   o_ld_data           formatted load result
//   o_misalign_err      one-cycle pulse, misaligned access rejected
//   o_bus_err           one-cycle pulse, no ack within TIMEOUT cycles
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid_in,
  input  logic        i_flush,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  input  logic [31:0] i_c,
  input  logic [31:0] i_rf_rd2,
  mem_access_if.master dm,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misalign_err,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state, w_next;
  logic             r_req, r_we, r_uns, r_misalign, r_bus_err;
  logic [31:0]      r_addr, r_wdata, r_ld;
  logic [3:0]       r_be;
  logic [1:0]       r_size, r_off;
  logic [CNT_W-1:0] r_cnt;

  logic        w_mem_op, w_aligned, w_start, w_ack_take, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_ld_fmt;

  assign w_mem_op = i_valid_in & ~i_flush & (i_mem_rd | i_mem_wr);

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b1111;
    w_wdata   = i_rf_rd2;
    case (i_mem_size)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << i_c[1:0];
        w_wdata   = {4{i_rf_rd2[7:0]}};
      end
      2'b01: begin
        w_aligned = ~i_c[0];
        w_be      = i_c[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{i_rf_rd2[15:0]}};
      end
      2'b10:   w_aligned = (i_c[1:0] == 2'b00);
      default: w_aligned = 1'b0;
    endcase
  end

  assign w_start = w_mem_op & w_aligned;

  // Move the addressed byte/half down to bit 0; word accesses have r_off==0.
  assign w_shift = dm.dm_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_ld_fmt = {{24{~r_uns & w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_ld_fmt = {{16{~r_uns & w_shift[15]}}, w_shift[15:0]};
      default: w_ld_fmt = w_shift;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_ack_take = 1'b0;
    w_timeout  = 1'b0;
    o_stall    = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_stall = w_start;
        if (w_start) w_next = S_REQ;
      end
      S_REQ: begin
        o_stall = 1'b1;
        if (dm.dm_ack) begin
          w_ack_take = 1'b1;
          w_next     = S_DONE;
        end else if (r_cnt == LP_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      // Inputs still describe the finished instruction here, so no start.
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_size     <= '0;
      r_uns      <= 1'b0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_ld       <= '0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) & w_mem_op & ~w_aligned;
      r_bus_err  <= w_timeout;
      if ((r_state == S_IDLE) && w_start) begin
        r_req   <= 1'b1;
        r_we    <= i_mem_wr;
        r_addr  <= {i_c[31:2], 2'b00};
        r_be    <= i_mem_wr ? w_be : 4'b1111;
        r_wdata <= i_mem_wr ? w_wdata : 32'd0;
        r_size  <= i_mem_size;
        r_uns   <= i_mem_unsigned;
        r_off   <= i_c[1:0];
        r_cnt   <= '0;
      end
      if (w_ack_take) begin
        r_req <= 1'b0;
        if (!r_we) r_ld <= w_ld_fmt;
      end else if (w_timeout) begin
        r_req <= 1'b0;
        r_ld  <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dm.dm_req      = r_req;
  assign dm.dm_we       = r_we;
  assign dm.dm_addr     = r_addr;
  assign dm.dm_wdata    = r_wdata;
  assign dm.dm_be       = r_be;
  assign o_ld_data      = r_ld;
  assign o_misalign_err = r_misalign;
  assign o_bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, flush = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, mem_uns = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] c_in = '0, rd2 = '0;
  logic        o_stall, o_done, o_misalign_err, o_bus_err;
  logic [31:0] o_ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid_in(valid_in), .i_flush(flush),
    .i_mem_rd(mem_rd), .i_mem_wr(mem_wr), .i_mem_size(mem_size),
    .i_mem_unsigned(mem_uns), .i_c(c_in), .i_rf_rd2(rd2), .dm(bus),
    .o_stall(o_stall), .o_done(o_done), .o_ld_data(o_ld_data),
    .o_misalign_err(o_misalign_err), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] w;
    byte         b;
    shortint     h;
    int          v;
    w = rdata >> (8 * off);
    if (size == 2'd0) begin
      b = w[7:0];
      v = b;
      return uns ? 32'(w[7:0]) : v;
    end else if (size == 2'd1) begin
      h = w[15:0];
      v = h;
      return uns ? 32'(w[15:0]) : v;
    end
    return rdata;
  endfunction

  // Transaction-level reference: what is outstanding, how long it has waited,
  // and what the port/result must show.
  bit          m_pending, m_finish, m_timeout, m_mis, m_we, m_uns;
  int          m_wait;
  logic [31:0] m_addr, m_wdata, m_ld;
  logic [3:0]  m_be;
  logic [1:0]  m_off, m_size;
  bit          e_op, e_al, e_start;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pending = 0; m_finish = 0; m_timeout = 0; m_mis = 0; m_we = 0; m_uns = 0;
      m_wait = 0; m_addr = '0; m_wdata = '0; m_ld = '0; m_be = '0; m_off = '0; m_size = '0;
    end
    e_op    = valid_in && !flush && (mem_rd || mem_wr);
    e_al    = (mem_size == 0) || (mem_size == 1 && c_in[0] == 0) || (mem_size == 2 && c_in[1:0] == 0);
    e_start = e_op && e_al;
    chk("m_req",    32'(bus.dm_req),        32'(m_pending));
    chk("m_we",     32'(bus.dm_we),         32'(m_we));
    chk("m_addr",   bus.dm_addr,            m_addr);
    chk("m_wdata",  bus.dm_wdata,           m_wdata);
    chk("m_be",     32'(bus.dm_be),         32'(m_be));
    chk("m_stall",  32'(o_stall),           32'(m_pending || (!m_finish && e_start)));
    chk("m_done",   32'(o_done),            32'(m_finish));
    chk("m_buserr", 32'(o_bus_err),         32'(m_finish && m_timeout));
    chk("m_mis",    32'(o_misalign_err),    32'(m_mis));
    chk("m_ld",     o_ld_data,              m_ld);
    if (rst_n) begin
      if (m_finish) begin
        m_finish = 0;
        m_mis    = 0;
      end else if (m_pending) begin
        m_mis = 0;
        if (bus.dm_ack) begin
          if (!m_we) m_ld = fmt_load(bus.dm_rdata, m_off, m_size, m_uns);
          m_pending = 0; m_finish = 1; m_timeout = 0;
        end else if (m_wait == TIMEOUT - 1) begin
          m_ld = '0;
          m_pending = 0; m_finish = 1; m_timeout = 1;
        end else begin
          m_wait++;
        end
      end else begin
        m_mis = e_op && !e_al;
        if (e_start) begin
          m_pending = 1; m_wait = 0;
          m_we   = mem_wr;
          m_addr = c_in & 32'hFFFF_FFFC;
          m_off  = c_in[1:0];
          m_size = mem_size;
          m_uns  = mem_uns;
          if (!mem_wr) begin
            m_be = 4'hF; m_wdata = '0;
          end else if (mem_size == 0) begin
            m_be = 4'(1 << c_in[1:0]); m_wdata = 32'(rd2[7:0]) * 32'h0101_0101;
          end else if (mem_size == 1) begin
            m_be = 4'(3 << c_in[1:0]); m_wdata = 32'(rd2[15:0]) * 32'h0001_0001;
          end else begin
            m_be = 4'hF; m_wdata = rd2;
          end
        end
      end
    end
  end

  int          t_stall, t_req, t_done, t_both, t_mis;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_be;

  // Presents one instruction, holding it until done (or dropping it at once
  // when no access starts), then one idle cycle. ack_n: REQ cycle carrying
  // dm_ack (0 = never). flush_at: cycle index with flush high (-1 = none).
  task automatic access(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] c, input logic [31:0] d, input logic [31:0] rdata,
                        input int ack_n, input int flush_at);
    int k;
    bit fin;
    k = 0; fin = 0;
    t_stall = 0; t_req = 0; t_done = 0; t_both = 0; t_mis = 0;
    t_addr = '0; t_wdata = '0; t_be = '0;
    valid_in = 1; mem_rd = rd; mem_wr = wr; mem_size = size; mem_uns = uns;
    c_in = c; rd2 = d; bus.dm_rdata = rdata;
    while (!fin && k < 60) begin
      bus.dm_ack = (ack_n > 0 && k == ack_n);
      flush = (k == flush_at);
      @(negedge clk);
      t_stall += int'(o_stall);
      t_req   += int'(bus.dm_req);
      t_done  += int'(o_done);
      t_both  += int'(o_done & o_bus_err);
      t_mis   += int'(o_misalign_err);
      if (k == 1) begin
        t_addr = bus.dm_addr; t_wdata = bus.dm_wdata; t_be = bus.dm_be;
      end
      if (o_done || (k == 0 && !o_stall)) fin = 1;
      @(posedge clk); #1;
      k++;
    end
    valid_in = 0; flush = 0; mem_rd = 0; mem_wr = 0; bus.dm_ack = 0;
    @(negedge clk);
    t_mis   += int'(o_misalign_err);
    t_req   += int'(bus.dm_req);
    t_stall += int'(o_stall);
    @(posedge clk); #1;
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL access_timeout actual=no_done required=done_within_60_cycles");
    end
  endtask

  initial begin
    bus.dm_ack = 0; bus.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(bus.dm_req), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_ld",    o_ld_data, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // SW, ack in third REQ cycle
    access(0, 1, 2'b10, 0, 32'h1000_0008, 32'hDEAD_BEEF, 32'h0, 3, -1);
    chk("sw_addr",  t_addr, 32'h1000_0008);
    chk("sw_be",    32'(t_be), 32'hF);
    chk("sw_wdata", t_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", t_stall, 4);
    chk("sw_done",  t_done, 1);

    // LB / LBU at byte 3, immediate ack
    access(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, -1);
    chk("lb_ld",    o_ld_data, 32'hFFFF_FF80);
    chk("lb_stall", t_stall, 2);
    chk("lb_be",    32'(t_be), 32'hF);
    access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, -1);
    chk("lbu_ld",   o_ld_data, 32'h0000_0080);

    // SH upper half, SB lane 1
    access(0, 1, 2'b01, 0, 32'h0000_0002, 32'h0000_ABCD, 32'h0, 1, -1);
    chk("sh_be",    32'(t_be), 32'hC);
    chk("sh_wdata", t_wdata, 32'hABCD_ABCD);
    access(0, 1, 2'b00, 0, 32'h0000_0005, 32'h1234_56A5, 32'h0, 2, -1);
    chk("sb_be",    32'(t_be), 32'h2);
    chk("sb_wdata", t_wdata, 32'hA5A5_A5A5);
    chk("sb_addr",  t_addr, 32'h0000_0004);
    chk("st_keeps_ld", o_ld_data, 32'h0000_0080);

    // Misaligned LH, reserved size
    access(1, 0, 2'b01, 0, 32'h0000_0001, 32'h0, 32'h0, 1, -1);
    chk("lh_mis",   t_mis, 1);
    chk("lh_req",   t_req, 0);
    chk("lh_stall", t_stall, 0);
    access(1, 0, 2'b11, 0, 32'h0000_0000, 32'h0, 32'h0, 1, -1);
    chk("sz3_mis",  t_mis, 1);

    // LH / LHU upper half
    access(1, 0, 2'b01, 0, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 1, -1);
    chk("lh_ld",    o_ld_data, 32'hFFFF_8001);
    access(1, 0, 2'b01, 1, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 1, -1);
    chk("lhu_ld",   o_ld_data, 32'h0000_8001);

    // Timeout
    access(1, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'h5555_5555, 0, -1);
    chk("to_req",   t_req, 16);
    chk("to_both",  t_both, 1);
    chk("to_done",  t_done, 1);
    chk("to_ld",    o_ld_data, 0);

    // Flush in IDLE, flush during REQ
    access(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0, 32'h1234_5678, 1, 0);
    chk("fl_idle_req",   t_req, 0);
    chk("fl_idle_stall", t_stall, 0);
    access(1, 0, 2'b10, 0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 2);
    chk("fl_req_done",   t_done, 1);
    chk("fl_req_ld",     o_ld_data, 32'h1234_5678);

    // Reset in the middle of REQ
    valid_in = 1; mem_rd = 1; mem_size = 2'b10; c_in = 32'h0000_0100; bus.dm_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(bus.dm_req), 1);
    @(posedge clk); #2;
    rst_n = 0; valid_in = 0; mem_rd = 0;
    #1;
    chk("mid_rst_req",   32'(bus.dm_req), 0);
    chk("mid_rst_stall", 32'(o_stall), 0);
    chk("mid_rst_done",  32'(o_done), 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    access(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1, -1);
    chk("post_rst_ld",   o_ld_data, 32'h0000_0080);
    chk("post_rst_done", t_done, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
